// File: rtl/uart_image_loader_pkg.sv
// Shared definitions for the UART image loader and its raster address generator.
//   IMG_W / IMG_H       image geometry in pixels
//   COL_BITS / ADDR_W   address layout: mem_addr = {row[COL_BITS-1:0], col[COL_BITS-1:0]}
//   PIX_W               width of the pixel counter
//   state_e             loader FSM state encoding
//   pixel_fmt()         raw UART pixel byte -> 32-bit fixed-point pixel word
package uart_image_loader_pkg;

   localparam int IMG_W    = 28;
   localparam int IMG_H    = 28;
   localparam int COL_BITS = 5;
   localparam int ADDR_W   = 2 * COL_BITS;
   localparam int PIX_W    = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Sign goes to bit 31. A positive byte carries an inverted magnitude on the
   // wire, so it is flipped back here before landing in bits [14:8].
   function automatic logic [31:0] pixel_fmt(input logic [7:0] b);
      logic [31:0] w;
      w        = '0;
      w[31]    = b[7];
      w[14:8]  = b[7] ? b[6:0] : ~b[6:0];
      return w;
   endfunction

endpackage

// File: rtl/uart_image_loader_raster_addr_gen.sv
// raster_addr_gen: row/col raster counter for image RAM addressing.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          force row = col = 0
//   adv          step to the next pixel in raster order (wraps to 0,0 after the last)
//   row, col     current position
//   last         current position is the final pixel of the image
module raster_addr_gen
   import uart_image_loader_pkg::*;
#(
   parameter int COLS     = IMG_W,
   parameter int ROWS     = IMG_H,
   parameter int CNT_BITS = COL_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                adv,
   output logic [CNT_BITS-1:0] row,
   output logic [CNT_BITS-1:0] col,
   output logic                last
);

   logic [CNT_BITS-1:0] row_q, row_d;
   logic [CNT_BITS-1:0] col_q, col_d;
   logic                col_end;

   assign col_end = (col_q == CNT_BITS'(COLS - 1));
   assign last    = col_end && (row_q == CNT_BITS'(ROWS - 1));
   assign row     = row_q;
   assign col     = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr || (adv && last)) begin
         row_d = '0;
         col_d = '0;
      end else if (adv) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/uart_image_loader.sv
// uart_image_loader: converts UART pixel bytes to 32-bit pixel words and writes
// them in raster order into the input image RAM, then pulses done.
// Optional feature: define IMG_CHECKSUM_EN to require a trailing 8-bit wrapping
// sum byte after the last pixel (state CHECK); a mismatch raises err.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 1-cycle pulse, begins one image (ignored while busy)
//   rx_valid, rx_data     byte strobe and data from uart_rx
//   mem_we/addr/wdata     image RAM write port, one cycle after each accepted byte
//   busy                  image in progress
//   done                  1-cycle pulse, image complete
//   err                   sticky timeout / checksum failure, cleared by next start
//   pix_count             pixels written in the current image
//
// state    | meaning
// ST_IDLE  | waiting for start, rx bytes ignored
// ST_RECV  | writing pixel bytes in raster order
// ST_CHECK | waiting for the checksum byte (IMG_CHECKSUM_EN only)
// ST_DONE  | one-cycle done pulse, back to IDLE
module uart_image_loader
   import uart_image_loader_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [PIX_W-1:0]  pix_count
);

   localparam int               TMR_W     = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(IMG_W * IMG_H);

   state_e              state_q, state_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [PIX_W-1:0]    pix_count_q, pix_count_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
`ifdef IMG_CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
`endif

   logic                rast_clr, rast_adv, rast_last;
   logic [COL_BITS-1:0] row, col;
   logic                timer_armed, timed_out;

   raster_addr_gen #(
      .COLS     (IMG_W),
      .ROWS     (IMG_H),
      .CNT_BITS (COL_BITS)
   ) u_raster (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rast_clr),
      .adv   (rast_adv),
      .row   (row),
      .col   (col),
      .last  (rast_last)
   );

   // The timer stays parked until the first pixel of the image has arrived,
   // so a host may take as long as it likes to begin sending.
   assign timer_armed = (pix_count_q != '0);
   // A byte arriving on the terminal cycle still counts as in time.
   assign timed_out   = timer_armed && !rx_valid && (timer_q == TMR_LAST);

   always_comb begin
      state_d     = state_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      pix_count_d = pix_count_q;
      timer_d     = timer_q;
      rast_clr    = 1'b0;
      rast_adv    = 1'b0;
`ifdef IMG_CHECKSUM_EN
      sum_d       = sum_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            busy_d  = 1'b0;
            timer_d = '0;
            // A byte arriving with start is dropped: the image begins after it.
            if (start) begin
               state_d     = ST_RECV;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               pix_count_d = '0;
               rast_clr    = 1'b1;
`ifdef IMG_CHECKSUM_EN
               sum_d       = '0;
`endif
            end
         end

         ST_RECV: begin
            if (rx_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = {row, col};
               mem_wdata_d = pixel_fmt(rx_data);
               rast_adv    = 1'b1;
               timer_d     = '0;
               if (pix_count_q != PIX_TOTAL) begin
                  pix_count_d = pix_count_q + 1'b1;
               end
`ifdef IMG_CHECKSUM_EN
               sum_d = sum_q + rx_data;
               if (rast_last) state_d = ST_CHECK;
`else
               if (rast_last) state_d = ST_DONE;
`endif
            end else if (timed_out) begin
               state_d  = ST_IDLE;
               busy_d   = 1'b0;
               err_d    = 1'b1;
               timer_d  = '0;
               rast_clr = 1'b1;
            end else if (timer_armed) begin
               timer_d = timer_q + 1'b1;
            end
         end

`ifdef IMG_CHECKSUM_EN
         ST_CHECK: begin
            if (rx_valid) begin
               timer_d = '0;
               if (rx_data == sum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end
            end else if (timed_out) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif

         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            timer_d = '0;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pix_count_q <= '0;
         timer_q     <= '0;
`ifdef IMG_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pix_count_q <= pix_count_d;
         timer_q     <= timer_d;
`ifdef IMG_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign pix_count = pix_count_q;

endmodule

// File: tb/tb_uart_image_loader.sv
`timescale 1ns/1ps
module tb_uart_image_loader;

   localparam int TO   = 16;
   localparam int NPIX = 784;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, done, err;
   logic [9:0]  pix_count;

   int checks   = 0;
   int failures = 0;

   uart_image_loader #(.TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .pix_count (pix_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         exp_done = 0;
   bit         m_active = 0;
   bit         m_err = 0;
   int         m_idx = 0;
   int         m_sum = 0;
   logic [9:0] got_addr28 = '0;
   logic [9:0] got_addr_last = '0;

   // Reference: sign in bit 31, magnitude (inverted on the wire when positive) at bit 8.
   function automatic logic [31:0] ref_fmt(input int b);
      if (b >= 128) return 32'h8000_0000 + 32'((b - 128) * 256);
      else          return 32'((127 - b) * 256);
   endfunction

   function automatic logic [9:0] ref_addr(input int i);
      return 10'((i / 28) * 32 + (i % 28));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or signals done.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", {63'd0, mem_we}, 64'd0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
               check("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
               if (e.idx == 28)       got_addr28    = mem_addr;
               if (e.idx == NPIX - 1) got_addr_last = mem_addr;
            end
         end
         if (done === 1'b1) begin
            if (exp_done == 0) begin
               check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
               exp_done--;
               check("busy_with_done", {63'd0, busy}, 64'd0);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_byte(input int b);
      if (m_active) begin
         if (m_idx < NPIX) begin
            wr_t e;
            e.idx  = m_idx;
            e.addr = ref_addr(m_idx);
            e.data = ref_fmt(b);
            exp_q.push_back(e);
            m_idx++;
            m_sum = (m_sum + b) % 256;
`ifndef IMG_CHECKSUM_EN
            if (m_idx == NPIX) begin
               m_active = 0;
               exp_done++;
            end
`endif
         end else begin
            m_active = 0;
            if (b == m_sum) exp_done++;
            else            m_err = 1;
         end
      end
   endtask

   task automatic send_byte(input int b, input int gap);
      rx_data  = 8'(b);
      rx_valid = 1'b1;
      model_byte(b);
      tick();
      rx_valid = 1'b0;
      tick(gap);
   endtask

   task automatic pulse_start(input bit with_byte, input int b);
      start = 1'b1;
      if (with_byte) begin
         rx_valid = 1'b1;
         rx_data  = 8'(b);
      end
      if (!m_active) begin
         m_active = 1;
         m_idx    = 0;
         m_sum    = 0;
         m_err    = 0;
      end else if (with_byte) begin
         model_byte(b);
      end
      tick();
      start    = 1'b0;
      rx_valid = 1'b0;
   endtask

   // fixed_val < 0 -> random bytes; csum < 0 -> correct checksum (checksum build only).
   task automatic send_image(input bit b2b, input int fixed_val, input int csum, input int mid_start);
      got_addr28    = '0;
      got_addr_last = '0;
      for (int i = 0; i < NPIX; i++) begin
         int b;
         b = (fixed_val < 0) ? int'($urandom_range(0, 255)) : fixed_val;
         if (i == mid_start) begin
            if (b2b) pulse_start(1, b);
            else begin
               pulse_start(0, 0);
               send_byte(b, 0);
            end
         end else begin
            send_byte(b, b2b ? 0 : int'($urandom_range(0, 5)));
         end
      end
`ifdef IMG_CHECKSUM_EN
      send_byte((csum < 0) ? m_sum : csum, 0);
`endif
   endtask

   task automatic end_phase(input string name);
      tick(6);
      check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
      check({name, "_pending_done"}, 64'(exp_done), 64'd0);
      check({name, "_err"}, {63'd0, err}, {63'd0, m_err});
      check({name, "_busy"}, {63'd0, busy}, {63'd0, m_active});
   endtask

   initial begin
      // Reset with rx_valid pulsing.
      rst_n   = 1'b0;
      rx_data = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         rx_valid = (i % 2 == 0);
         tick();
      end
      rx_valid = 1'b0;
      check("rst_mem_we", {63'd0, mem_we}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_pix_count", {54'd0, pix_count}, 64'd0);
      rst_n = 1'b1;
      tick(2);

      // Bytes in IDLE are ignored.
      send_byte(8'h33, 2);
      check("idle_pix_count", {54'd0, pix_count}, 64'd0);

      // Format: 0x85 -> 0x80000500 @0x000, 0x05 -> 0x00007A00 @0x001.
      pulse_start(0, 0);
      check("start_busy", {63'd0, busy}, 64'd1);
      send_byte(8'h85, 0);
      send_byte(8'h05, 0);
      tick();
      check("fmt_pix_count", {54'd0, pix_count}, 64'd2);

      // Timeout: 10 bytes total, then silence.
      for (int i = 0; i < 7; i++) send_byte(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      send_byte(int'($urandom_range(0, 255)), 0);
      tick(15);
      check("to_err_before", {63'd0, err}, 64'd0);
      check("to_busy_before", {63'd0, busy}, 64'd1);
      tick(1);
      check("to_err_at", {63'd0, err}, 64'd1);
      check("to_busy_at", {63'd0, busy}, 64'd0);
      check("to_pix_count", {54'd0, pix_count}, 64'd10);
      m_active = 0;
      m_err    = 1;
      end_phase("timeout");

      // New start clears err; timer not armed before the first byte.
      pulse_start(0, 0);
      check("restart_err", {63'd0, err}, 64'd0);
      tick(40);
      check("unarmed_busy", {63'd0, busy}, 64'd1);
      check("unarmed_err", {63'd0, err}, 64'd0);

      // Reset mid-image.
      for (int i = 0; i < 5; i++) send_byte(int'($urandom_range(0, 255)), 0);
      rst_n = 1'b0;
      tick(2);
      m_active = 0;
      m_err    = 0;
      m_idx    = 0;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_mem_we", {63'd0, mem_we}, 64'd0);
      check("midrst_pix_count", {54'd0, pix_count}, 64'd0);
      rst_n = 1'b1;
      tick(2);
      end_phase("midrst");

      // Start with a byte in the same cycle (dropped), random gaps, start mid-image.
      pulse_start(1, 8'h7E);
      send_image(0, -1, -1, 300);
      end_phase("rand_img");
      check("rand_pix_count", {54'd0, pix_count}, 64'd784);
      check("rand_addr28", {54'd0, got_addr28}, 64'h020);
      check("rand_addr_last", {54'd0, got_addr_last}, 64'h37B);

      // Back-to-back full image, start+byte collision mid-image.
      pulse_start(0, 0);
      send_image(1, -1, -1, 400);
      end_phase("b2b_img");
      check("b2b_pix_count", {54'd0, pix_count}, 64'd784);
      check("b2b_addr28", {54'd0, got_addr28}, 64'h020);
      check("b2b_addr_last", {54'd0, got_addr_last}, 64'h37B);

`ifdef IMG_CHECKSUM_EN
      pulse_start(0, 0);
      send_image(1, 1, 8'h10, -1);
      end_phase("csum_ok");
      check("csum_ok_err", {63'd0, err}, 64'd0);
      pulse_start(0, 0);
      send_image(1, 1, 8'h11, -1);
      end_phase("csum_bad");
      check("csum_bad_err", {63'd0, err}, 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
